// File: rtl/alu_share_arb.sv
// Round-robin (or fixed-priority) sharing of one combinational ALU among NREQ
// issue requesters, with a single registered result stage tagged by requester id.

package alu_share_pkg;

  parameter int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_ALUI   = 2'd1,
    FU_BRANCH = 2'd2,
    FU_AUIPC  = 2'd3
  } fu_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_func_e;

  typedef enum logic [3:0] {
    BR_BEQ  = 4'd0,
    BR_BNE  = 4'd1,
    BR_BLT  = 4'd4,
    BR_BGE  = 4'd5,
    BR_BLTU = 4'd6,
    BR_BGEU = 4'd7
  } br_func_e;

  // fu_func is interpreted as alu_func_e or br_func_e depending on fu_op
  typedef struct packed {
    fu_op_e          fu_op;
    logic [3:0]      fu_func;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } uop_info_t;

endpackage

module alu_share_arb_alu
  import alu_share_pkg::*;
(
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  uop_info_t       uop_i,
  output logic [XLEN-1:0] res_o,
  output logic            jump_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] target;
  logic [SHW-1:0]  shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            br_taken;

  always_comb begin
    op_b   = (uop_i.fu_op == FU_ALUI) ? uop_i.imm : rs2_i;
    shamt  = op_b[SHW-1:0];
    lt_s   = $signed(rs1_i) < $signed(op_b);
    lt_u   = rs1_i < op_b;
    eq     = rs1_i == op_b;
    target = uop_i.pc + uop_i.imm;

    alu_res = '0;
    unique case (alu_func_e'(uop_i.fu_func))
      ALU_ADD:  alu_res = rs1_i + op_b;
      ALU_SUB:  alu_res = rs1_i - op_b;
      ALU_SLL:  alu_res = rs1_i << shamt;
      ALU_SLT:  alu_res = XLEN'(lt_s);
      ALU_SLTU: alu_res = XLEN'(lt_u);
      ALU_XOR:  alu_res = rs1_i ^ op_b;
      ALU_SRL:  alu_res = rs1_i >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(rs1_i) >>> shamt);
      ALU_OR:   alu_res = rs1_i | op_b;
      ALU_AND:  alu_res = rs1_i & op_b;
      default:  alu_res = '0;
    endcase

    br_taken = 1'b0;
    unique case (br_func_e'(uop_i.fu_func))
      BR_BEQ:  br_taken = eq;
      BR_BNE:  br_taken = ~eq;
      BR_BLT:  br_taken = lt_s;
      BR_BGE:  br_taken = ~lt_s;
      BR_BLTU: br_taken = lt_u;
      BR_BGEU: br_taken = ~lt_u;
      default: br_taken = 1'b0;
    endcase

    res_o  = '0;
    jump_o = 1'b0;
    unique case (uop_i.fu_op)
      FU_ALU, FU_ALUI: res_o = alu_res;
      FU_BRANCH: begin
        res_o  = target;
        jump_o = br_taken;
      end
      FU_AUIPC:  res_o = target;
      default:   res_o = '0;
    endcase
  end

endmodule

module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned IDW       = $clog2(NREQ),
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*XLEN-1:0] req_rs1_i,
  input  logic [NREQ*XLEN-1:0] req_rs2_i,
  input  uop_info_t [NREQ-1:0] req_uop_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IDW-1:0]       resp_id_o,
  output logic [XLEN-1:0]      resp_res_o,
  output logic                 resp_jump_o,
  output logic [XLEN-1:0]      resp_pc_o
);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  base;
  logic [IDW-1:0]  cand_id;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  rr_next;
  logic            any_valid;
  logic [NREQ-1:0] grant;
  logic            stage_free;
  logic            accept_ok;
  logic            transfer;

  logic [XLEN-1:0] rs1_arr [NREQ];
  logic [XLEN-1:0] rs2_arr [NREQ];

  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  uop_info_t       alu_uop;
  logic [XLEN-1:0] alu_res;
  logic            alu_jump;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rs1_arr[g] = req_rs1_i[g*XLEN +: XLEN];
    assign rs2_arr[g] = req_rs2_i[g*XLEN +: XLEN];
  end

  // Search starts at rr_ptr and wraps; first valid requester found wins.
  always_comb begin
    base      = FIXED_PRI ? '0 : rr_ptr;
    any_valid = 1'b0;
    win_id    = '0;
    cand_id   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_id = IDW'((32'(base) + i) % NREQ);
      if (!any_valid && req_valid_i[cand_id]) begin
        any_valid = 1'b1;
        win_id    = cand_id;
      end
    end

    grant = '0;
    grant[win_id] = any_valid;

    stage_free  = ~resp_valid_o | resp_ready_i;
    accept_ok   = stage_free & ~flush_i & rst_ni;
    req_ready_o = grant & {NREQ{accept_ok}};
    transfer    = any_valid & accept_ok;

    rr_next = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;

    alu_rs1 = rs1_arr[win_id];
    alu_rs2 = rs2_arr[win_id];
    alu_uop = req_uop_i[win_id];
  end

  alu_share_arb_alu u_alu (
    .rs1_i  (alu_rs1),
    .rs2_i  (alu_rs2),
    .uop_i  (alu_uop),
    .res_o  (alu_res),
    .jump_o (alu_jump)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr       <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_res_o   <= '0;
      resp_jump_o  <= 1'b0;
      resp_pc_o    <= '0;
    end else begin
      if (flush_i)           resp_valid_o <= 1'b0;
      else if (transfer)     resp_valid_o <= 1'b1;
      else if (resp_ready_i) resp_valid_o <= 1'b0;

      if (transfer) begin
        resp_id_o   <= win_id;
        resp_res_o  <= alu_res;
        resp_jump_o <= alu_jump;
        resp_pc_o   <= alu_uop.pc;
        if (!FIXED_PRI) rr_ptr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed table-driven bench for alu_share_arb (NREQ=2, round-robin), plus
// hand-written sequences for the async reset corner.

module tb_alu_share_arb;
  import alu_share_pkg::*;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 flush_i;
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [2*XLEN-1:0]    req_rs1_i;
  logic [2*XLEN-1:0]    req_rs2_i;
  uop_info_t [1:0]      req_uop_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [0:0]           resp_id_o;
  logic [XLEN-1:0]      resp_res_o;
  logic                 resp_jump_o;
  logic [XLEN-1:0]      resp_pc_o;

  alu_share_arb #(.NREQ(2), .FIXED_PRI(1'b0)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_uop_i    (req_uop_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_id_o    (resp_id_o),
    .resp_res_o   (resp_res_o),
    .resp_jump_o  (resp_jump_o),
    .resp_pc_o    (resp_pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  valid;
    logic        rready;
    logic        flush;
    logic [31:0] rs1_0, rs2_0;
    uop_info_t   uop0;
    logic [31:0] rs1_1, rs2_1;
    uop_info_t   uop1;
    logic [1:0]  e_ready;
    logic        e_valid;
    logic        e_id;
    logic [31:0] e_res;
    logic        e_jump;
    logic [31:0] e_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs [18];

  function automatic uop_info_t u(input fu_op_e op, input logic [3:0] f, input logic [31:0] pc, input logic [31:0] imm);
    uop_info_t r;
    r.fu_op = op; r.fu_func = f; r.pc = pc; r.imm = imm;
    return r;
  endfunction

  function automatic vec_t mv(input logic [1:0] valid, input logic rready, input logic flush,
                              input logic [31:0] rs1_0, input logic [31:0] rs2_0, input uop_info_t uop0,
                              input logic [31:0] rs1_1, input logic [31:0] rs2_1, input uop_info_t uop1,
                              input logic [1:0] e_ready, input logic e_valid, input logic e_id,
                              input logic [31:0] e_res, input logic e_jump, input logic [31:0] e_pc);
    vec_t v;
    v.valid = valid; v.rready = rready; v.flush = flush;
    v.rs1_0 = rs1_0; v.rs2_0 = rs2_0; v.uop0 = uop0;
    v.rs1_1 = rs1_1; v.rs2_1 = rs2_1; v.uop1 = uop1;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_id = e_id;
    v.e_res = e_res; v.e_jump = e_jump; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid_i  = v.valid;
    resp_ready_i = v.rready;
    flush_i      = v.flush;
    req_rs1_i    = {v.rs1_1, v.rs1_0};
    req_rs2_i    = {v.rs2_1, v.rs2_0};
    req_uop_i[0] = v.uop0;
    req_uop_i[1] = v.uop1;
  endtask

  uop_info_t nop, add200, sub300, sll304, xor204, sra308, or208;
  uop_info_t blt400, bltu404, beq408, addi500, slt504, sltu600, add700, add800;

  initial begin
    nop     = u(FU_ALU,    ALU_ADD,  32'h0,     32'h0);
    add200  = u(FU_ALU,    ALU_ADD,  32'h200,   32'h0);
    sub300  = u(FU_ALU,    ALU_SUB,  32'h300,   32'h0);
    sll304  = u(FU_ALU,    ALU_SLL,  32'h304,   32'h0);
    xor204  = u(FU_ALU,    ALU_XOR,  32'h204,   32'h0);
    sra308  = u(FU_ALU,    ALU_SRA,  32'h308,   32'h0);
    or208   = u(FU_ALU,    ALU_OR,   32'h208,   32'h0);
    blt400  = u(FU_BRANCH, BR_BLT,   32'h400,   32'h20);
    bltu404 = u(FU_BRANCH, BR_BLTU,  32'h404,   32'h20);
    beq408  = u(FU_BRANCH, BR_BEQ,   32'h408,   32'hFFFF_FFF8);
    addi500 = u(FU_ALUI,   ALU_ADD,  32'h500,   32'hFFFF_FFFF);
    slt504  = u(FU_ALU,    ALU_SLT,  32'h504,   32'h0);
    sltu600 = u(FU_ALU,    ALU_SLTU, 32'h600,   32'h0);
    add700  = u(FU_ALU,    ALU_ADD,  32'h700,   32'h0);
    add800  = u(FU_ALU,    ALU_ADD,  32'h800,   32'h0);

    //            valid  rr fl  rs1_0         rs2_0  uop0     rs1_1         rs2_1  uop1     e_rdy e_v id  e_res          jmp e_pc
    vecs[0]  = mv(2'b01, 1, 0, 32'd5,        32'd7, u(FU_ALU, ALU_ADD, 32'h100, 0), 0, 0, nop, 2'b01, 1, 0, 32'd12, 0, 32'h100);
    vecs[1]  = mv(2'b11, 1, 0, 32'd1,        32'd2, add200,  32'd10,       32'd3, sub300,  2'b10, 1, 1, 32'd7,          0, 32'h300);
    vecs[2]  = mv(2'b11, 1, 0, 32'd1,        32'd2, add200,  32'd1,        32'd4, sll304,  2'b01, 1, 0, 32'd3,          0, 32'h200);
    vecs[3]  = mv(2'b11, 1, 0, 32'hF0,       32'hFF, xor204, 32'd1,        32'd4, sll304,  2'b10, 1, 1, 32'd16,         0, 32'h304);
    vecs[4]  = mv(2'b11, 1, 0, 32'hF0,       32'hFF, xor204, 32'h8000_0000, 32'd4, sra308, 2'b01, 1, 0, 32'h0F,         0, 32'h204);
    vecs[5]  = mv(2'b11, 0, 0, 32'h10,       32'h01, or208,  32'h8000_0000, 32'd4, sra308, 2'b00, 1, 0, 32'h0F,         0, 32'h204);
    vecs[6]  = mv(2'b11, 0, 0, 32'h10,       32'h01, or208,  32'h8000_0000, 32'd4, sra308, 2'b00, 1, 0, 32'h0F,         0, 32'h204);
    vecs[7]  = mv(2'b11, 0, 0, 32'h10,       32'h01, or208,  32'h8000_0000, 32'd4, sra308, 2'b00, 1, 0, 32'h0F,         0, 32'h204);
    vecs[8]  = mv(2'b11, 1, 0, 32'h10,       32'h01, or208,  32'h8000_0000, 32'd4, sra308, 2'b10, 1, 1, 32'hF800_0000,  0, 32'h308);
    vecs[9]  = mv(2'b11, 1, 0, 32'h10,       32'h01, or208,  32'hFFFF_FFFF, 32'd1, blt400, 2'b01, 1, 0, 32'h11,         0, 32'h208);
    vecs[10] = mv(2'b10, 1, 0, 32'd0,        32'd0, nop,     32'hFFFF_FFFF, 32'd1, blt400, 2'b10, 1, 1, 32'h420,        1, 32'h400);
    vecs[11] = mv(2'b10, 1, 0, 32'd0,        32'd0, nop,     32'hFFFF_FFFF, 32'd1, bltu404, 2'b10, 1, 1, 32'h424,       0, 32'h404);
    vecs[12] = mv(2'b10, 1, 0, 32'd0,        32'd0, nop,     32'd5,        32'd5, beq408,  2'b10, 1, 1, 32'h400,        1, 32'h408);
    vecs[13] = mv(2'b00, 1, 0, 32'd0,        32'd0, nop,     32'd0,        32'd0, nop,     2'b00, 0, 0, 32'h0,          0, 32'h0);
    vecs[14] = mv(2'b01, 1, 0, 32'd100,      32'd7, addi500, 32'd0,        32'd0, nop,     2'b01, 1, 0, 32'd99,         0, 32'h500);
    vecs[15] = mv(2'b11, 0, 1, 32'hFFFF_FFFF, 32'd0, slt504, 32'hFFFF_FFFF, 32'd0, sltu600, 2'b00, 0, 0, 32'h0,         0, 32'h0);
    vecs[16] = mv(2'b11, 1, 0, 32'hFFFF_FFFF, 32'd0, slt504, 32'hFFFF_FFFF, 32'd0, sltu600, 2'b10, 1, 1, 32'd0,         0, 32'h600);
    vecs[17] = mv(2'b01, 1, 0, 32'hFFFF_FFFF, 32'd0, slt504, 32'd0,        32'd0, nop,     2'b01, 1, 0, 32'd1,          0, 32'h504);

    rst_ni = 1'b0;
    drive(mv(2'b11, 1, 0, 32'd1, 32'd1, add200, 32'd1, 32'd1, sub300, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("rst ready",  32'(req_ready_o),  32'd0);
    chk("rst valid",  32'(resp_valid_o), 32'd0);
    chk("rst id",     32'(resp_id_o),    32'd0);
    chk("rst res",    resp_res_o,        32'd0);
    chk("rst jump",   32'(resp_jump_o),  32'd0);
    chk("rst pc",     resp_pc_o,         32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d ready", i), 32'(req_ready_o), 32'(vecs[i].e_ready));
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid_o), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d id", i),   32'(resp_id_o),   32'(vecs[i].e_id));
        chk($sformatf("v%0d res", i),  resp_res_o,       vecs[i].e_res);
        chk($sformatf("v%0d jump", i), 32'(resp_jump_o), 32'(vecs[i].e_jump));
        chk($sformatf("v%0d pc", i),   resp_pc_o,        vecs[i].e_pc);
      end
      @(negedge clk_i);
    end

    // rr_ptr is 1 here, so requester 1 wins before the mid-stream reset
    drive(mv(2'b11, 1, 0, 32'd2, 32'd3, add700, 32'd4, 32'd4, add800, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("pre-rst ready", 32'(req_ready_o), 32'b10);
    @(posedge clk_i);
    #1;
    chk("pre-rst valid", 32'(resp_valid_o), 32'd1);
    chk("pre-rst res",   resp_res_o,        32'd8);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async rst valid", 32'(resp_valid_o), 32'd0);
    chk("async rst id",    32'(resp_id_o),    32'd0);
    chk("async rst res",   resp_res_o,        32'd0);
    chk("async rst jump",  32'(resp_jump_o),  32'd0);
    chk("async rst pc",    resp_pc_o,         32'd0);
    chk("async rst ready", 32'(req_ready_o),  32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_valid_i = 2'b00;
    #1;
    chk("post-rst idle ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("no replay valid", 32'(resp_valid_o), 32'd0);
    @(negedge clk_i);
    req_valid_i = 2'b11;
    #1;
    chk("post-rst ready", 32'(req_ready_o), 32'b01);
    @(posedge clk_i);
    #1;
    chk("post-rst valid", 32'(resp_valid_o), 32'd1);
    chk("post-rst id",    32'(resp_id_o),    32'd0);
    chk("post-rst res",   resp_res_o,        32'd5);
    chk("post-rst pc",    resp_pc_o,         32'h700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
